// File: rtl/game_sequencer_pkg.sv
// Shared encodings for the game sequencer: commands, key codes and FSM states.
package game_sequencer_pkg;

    typedef enum logic [3:0] {
        CMD_NONE    = 4'd0,
        CMD_SPAWN   = 4'd1,
        CMD_ROT_CW  = 4'd2,
        CMD_ROT_CCW = 4'd3,
        CMD_LEFT    = 4'd4,
        CMD_RIGHT   = 4'd5,
        CMD_DOWN    = 4'd6,
        CMD_LOCK    = 4'd7,
        CMD_ELIM    = 4'd8,
        CMD_CLEAR   = 4'd9
    } cmd_t;

    localparam logic [2:0] KEY_ESC   = 3'd1;
    localparam logic [2:0] KEY_SPACE = 3'd2;
    localparam logic [2:0] KEY_CW    = 3'd3;
    localparam logic [2:0] KEY_CCW   = 3'd4;
    localparam logic [2:0] KEY_LEFT  = 3'd5;
    localparam logic [2:0] KEY_RIGHT = 3'd6;

    // Most rows a single lock can clear.
    localparam logic [2:0] MAX_ROWS = 3'd4;

    typedef enum logic [3:0] {
        ST_CLEAR,
        ST_SPAWN,
        ST_SPAWN_CHK,
        ST_PLAY,
        ST_FALL,
        ST_DROP,
        ST_LOCK,
        ST_ELIM,
        ST_SCORE,
        ST_OVER,
        ST_WAIT
    } state_t;

    // Keys that go through the buffer (everything except esc and the unused codes).
    function automatic logic is_move_key(input logic [2:0] code);
        return (code >= KEY_SPACE) && (code <= KEY_RIGHT);
    endfunction

endpackage

// File: rtl/game_sequencer_key_fifo.sv
// Small key-event buffer. A push while full is discarded; pop while empty is ignored.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; clear behaves like a reset for the control state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: turns key presses and gravity into one-cycle datapath commands.
//
// state      | meaning
// CLEAR      | issue clear_board, then spawn
// SPAWN      | issue spawn
// SPAWN_CHK  | new piece collides -> OVER, else PLAY
// PLAY       | idle; pending gravity first, then one buffered key
// FALL       | gravity step down, or lock when blocked
// DROP       | hard drop: step down every visit until blocked
// LOCK       | issue lock, zero row counter
// ELIM       | eliminate full rows, up to four
// SCORE      | report rows cleared, respawn or end
// OVER       | game ended, waits for esc
// WAIT       | SETTLE cycles after a command, then saved return state
module game_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [2:0] key_code,
    input  logic       gravity_tick,
    input  logic       cw_ok,
    input  logic       ccw_ok,
    input  logic       left_ok,
    input  logic       right_ok,
    input  logic       down_ok,
    input  logic       cur_ok,
    input  logic       top_out,
    input  logic       row_full,
    output logic [3:0] cmd,
    output logic       score_hit,
    output logic [2:0] line_cnt,
    output logic       game_over,
    output logic       busy,
    output logic       key_dropped
);

    import game_sequencer_pkg::*;

    localparam logic [2:0] SETTLE_M1 = 3'(SETTLE - 1);

    state_t     state, state_nxt;
    state_t     ret_state, ret_nxt;
    state_t     wait_to;
    logic       enter_wait;
    logic [2:0] wait_cnt, wait_nxt;
    logic [2:0] row_cnt, row_nxt;
    logic       grav_pend, grav_clr;
    cmd_t       cmd_q, cmd_nxt;
    logic       score_nxt;
    logic [2:0] line_nxt;

    logic       esc;
    logic       fifo_push;
    logic       fifo_pop;
    logic [2:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;

    assign esc       = key_valid && (key_code == KEY_ESC);
    assign fifo_push = key_valid && is_move_key(key_code) && (state != ST_OVER);
    assign cmd       = cmd_q;

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_key_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (esc),
        .push  (fifo_push),
        .din   (key_code),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, command and bookkeeping decode.
    always_comb begin
        state_nxt  = state;
        ret_nxt    = ret_state;
        wait_nxt   = wait_cnt;
        row_nxt    = row_cnt;
        cmd_nxt    = CMD_NONE;
        score_nxt  = 1'b0;
        line_nxt   = line_cnt;
        fifo_pop   = 1'b0;
        grav_clr   = 1'b0;
        enter_wait = 1'b0;
        wait_to    = ST_PLAY;

        if (esc) begin
            state_nxt = ST_CLEAR;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cmd_nxt    = CMD_CLEAR;
                    enter_wait = 1'b1;
                    wait_to    = ST_SPAWN;
                end
                ST_SPAWN: begin
                    cmd_nxt    = CMD_SPAWN;
                    enter_wait = 1'b1;
                    wait_to    = ST_SPAWN_CHK;
                end
                ST_SPAWN_CHK: begin
                    state_nxt = cur_ok ? ST_PLAY : ST_OVER;
                end
                ST_PLAY: begin
                    if (grav_pend) begin
                        state_nxt = ST_FALL;
                        grav_clr  = 1'b1;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        case (fifo_dout)
                            KEY_SPACE: state_nxt = ST_DROP;
                            KEY_CW: if (cw_ok) begin
                                cmd_nxt    = CMD_ROT_CW;
                                enter_wait = 1'b1;
                            end
                            KEY_CCW: if (ccw_ok) begin
                                cmd_nxt    = CMD_ROT_CCW;
                                enter_wait = 1'b1;
                            end
                            KEY_LEFT: if (left_ok) begin
                                cmd_nxt    = CMD_LEFT;
                                enter_wait = 1'b1;
                            end
                            KEY_RIGHT: if (right_ok) begin
                                cmd_nxt    = CMD_RIGHT;
                                enter_wait = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_FALL: begin
                    if (down_ok) begin
                        cmd_nxt    = CMD_DOWN;
                        enter_wait = 1'b1;
                    end else begin
                        state_nxt = ST_LOCK;
                    end
                end
                ST_DROP: begin
                    if (down_ok) begin
                        cmd_nxt    = CMD_DOWN;
                        enter_wait = 1'b1;
                        wait_to    = ST_DROP;
                    end else begin
                        // Gravity that arrived mid-drop is moot once the piece locks.
                        state_nxt = ST_LOCK;
                        grav_clr  = 1'b1;
                    end
                end
                ST_LOCK: begin
                    cmd_nxt    = CMD_LOCK;
                    row_nxt    = 3'd0;
                    enter_wait = 1'b1;
                    wait_to    = ST_ELIM;
                end
                ST_ELIM: begin
                    if (row_full && (row_cnt < MAX_ROWS)) begin
                        cmd_nxt    = CMD_ELIM;
                        row_nxt    = row_cnt + 3'd1;
                        enter_wait = 1'b1;
                        wait_to    = ST_ELIM;
                    end else begin
                        state_nxt = ST_SCORE;
                    end
                end
                ST_SCORE: begin
                    if (row_cnt != 3'd0) begin
                        score_nxt = 1'b1;
                        line_nxt  = row_cnt - 3'd1;
                    end
                    state_nxt = top_out ? ST_OVER : ST_SPAWN;
                end
                ST_OVER: begin
                    state_nxt = ST_OVER;
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state_nxt = ret_state;
                    end else begin
                        wait_nxt = wait_cnt - 3'd1;
                    end
                end
                default: state_nxt = ST_CLEAR;
            endcase

            if (enter_wait) begin
                state_nxt = ST_WAIT;
                ret_nxt   = wait_to;
                wait_nxt  = SETTLE_M1;
            end
        end
    end

    // State register and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_CLEAR;
            ret_state   <= ST_SPAWN;
            wait_cnt    <= 3'd0;
            row_cnt     <= 3'd0;
            grav_pend   <= 1'b0;
            cmd_q       <= CMD_NONE;
            score_hit   <= 1'b0;
            line_cnt    <= 3'd0;
            game_over   <= 1'b0;
            busy        <= 1'b1;
            key_dropped <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            wait_cnt  <= wait_nxt;
            row_cnt   <= row_nxt;
            cmd_q     <= cmd_nxt;
            score_hit <= score_nxt;
            line_cnt  <= line_nxt;
            game_over <= (state_nxt == ST_OVER);
            busy      <= (state_nxt != ST_PLAY);

            // A fresh tick outranks a clear in the same cycle so it is never lost.
            if (gravity_tick && (state != ST_OVER)) begin
                grav_pend <= 1'b1;
            end else if (grav_clr) begin
                grav_pend <= 1'b0;
            end

            if (esc) begin
                key_dropped <= 1'b0;
            end else if (fifo_push && fifo_full) begin
                key_dropped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_game_sequencer;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [2:0] key_code = 3'd0;
    logic       gravity_tick = 1'b0;
    logic       cw_ok = 1'b1;
    logic       ccw_ok = 1'b1;
    logic       left_ok = 1'b1;
    logic       right_ok = 1'b1;
    logic       down_ok = 1'b0;
    logic       cur_ok = 1'b1;
    logic       top_out = 1'b0;
    logic       row_full = 1'b0;
    logic [3:0] cmd;
    logic       score_hit;
    logic [2:0] line_cnt;
    logic       game_over;
    logic       busy;
    logic       key_dropped;

    int n_assert = 0;
    int n_fail   = 0;

    game_sequencer #(
        .FIFO_DEPTH (4),
        .SETTLE     (SETTLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .gravity_tick (gravity_tick),
        .cw_ok        (cw_ok),
        .ccw_ok       (ccw_ok),
        .left_ok      (left_ok),
        .right_ok     (right_ok),
        .down_ok      (down_ok),
        .cur_ok       (cur_ok),
        .top_out      (top_out),
        .row_full     (row_full),
        .cmd          (cmd),
        .score_hit    (score_hit),
        .line_cnt     (line_cnt),
        .game_over    (game_over),
        .busy         (busy),
        .key_dropped  (key_dropped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance until a command shows up (bounded), then check it; gap = cycles waited.
    task automatic wait_cmd(input string tag, input logic [3:0] exp, input int max, output int gap);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (cmd === 4'd0 && gap < max);
        check(tag, 32'(cmd), 32'(exp));
    endtask

    // Run n cycles and require that no command is issued.
    task automatic quiet(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (cmd !== 4'd0) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic press(input logic [2:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        key_code  = 3'd0;
    endtask

    initial begin
        int gap;

        // Reset values
        repeat (3) tick();
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_key_dropped", 32'(key_dropped), 32'd0);
        check("rst_score_hit", 32'(score_hit), 32'd0);
        check("rst_line_cnt", 32'(line_cnt), 32'd0);

        // Boot: clear_board, spawn SETTLE+1 later, then PLAY
        rst = 1'b0;
        wait_cmd("boot_clear", 4'd9, 10, gap);
        check("boot_clear_lat", 32'(gap), 32'd1);
        wait_cmd("boot_spawn", 4'd1, 10, gap);
        check("boot_spawn_gap", 32'(gap), 32'(SETTLE + 1));
        tick();
        tick();
        check("boot_busy_hold", 32'(busy), 32'd1);
        tick();
        check("boot_play_busy", 32'(busy), 32'd0);

        // Esc then five lefts back to back while restarting: four buffered, fifth dropped
        key_valid = 1'b1;
        key_code  = 3'd1;
        tick();
        key_code  = 3'd5;
        repeat (5) tick();
        key_valid = 1'b0;
        key_code  = 3'd0;
        check("fifo_overflow_dropped", 32'(key_dropped), 32'd1);
        wait_cmd("left_1", 4'd4, 12, gap);
        for (int i = 2; i <= 4; i++) begin
            wait_cmd("left_n", 4'd4, 12, gap);
            check("left_spacing", 32'(gap), 32'(SETTLE + 1));
        end
        quiet("left_fifth_lost", 10);
        check("left_idle_busy", 32'(busy), 32'd0);

        // Rejected right, ignored codes 7 and 0
        right_ok = 1'b0;
        press(3'd6);
        press(3'd7);
        press(3'd0);
        quiet("reject_silent", 8);
        check("reject_busy", 32'(busy), 32'd0);
        right_ok = 1'b1;

        // Accepted rotation
        press(3'd3);
        wait_cmd("rot_cw", 4'd2, 8, gap);
        tick();
        tick();
        check("rot_back_play", 32'(busy), 32'd0);

        // Gravity step with room below
        down_ok      = 1'b1;
        gravity_tick = 1'b1;
        tick();
        gravity_tick = 1'b0;
        wait_cmd("fall_down", 4'd6, 8, gap);
        tick();
        tick();
        check("fall_back_play", 32'(busy), 32'd0);

        // Hard drop: three steps, gravity ticks meanwhile, then lock
        press(3'd2);
        wait_cmd("drop_down_1", 4'd6, 8, gap);
        gravity_tick = 1'b1;
        tick();
        gravity_tick = 1'b0;
        wait_cmd("drop_down_2", 4'd6, 8, gap);
        gravity_tick = 1'b1;
        tick();
        gravity_tick = 1'b0;
        wait_cmd("drop_down_3", 4'd6, 8, gap);
        gravity_tick = 1'b1;
        down_ok      = 1'b0;
        tick();
        gravity_tick = 1'b0;
        wait_cmd("drop_lock", 4'd7, 8, gap);
        wait_cmd("drop_respawn", 4'd1, 20, gap);
        repeat (3) tick();
        check("respawn_play", 32'(busy), 32'd0);
        quiet("no_fall_after_drop", 8);

        // Gravity into a blocked piece, two full rows
        gravity_tick = 1'b1;
        tick();
        gravity_tick = 1'b0;
        wait_cmd("fall_lock", 4'd7, 8, gap);
        row_full = 1'b1;
        wait_cmd("elim_1", 4'd8, 8, gap);
        wait_cmd("elim_2", 4'd8, 8, gap);
        row_full = 1'b0;
        cur_ok   = 1'b0;
        repeat (3) tick();
        check("score_not_yet", 32'(score_hit), 32'd0);
        tick();
        check("score_hit", 32'(score_hit), 32'd1);
        check("score_line_cnt", 32'(line_cnt), 32'd1);
        tick();
        check("score_pulse_end", 32'(score_hit), 32'd0);
        check("score_respawn", 32'(cmd), 32'd1);

        // Spawn collides -> game over; gravity and keys ignored; esc restarts
        tick();
        tick();
        check("over_not_yet", 32'(game_over), 32'd0);
        tick();
        check("over_set", 32'(game_over), 32'd1);
        check("over_busy", 32'(busy), 32'd1);
        cur_ok       = 1'b1;
        gravity_tick = 1'b1;
        key_valid    = 1'b1;
        key_code     = 3'd5;
        tick();
        gravity_tick = 1'b0;
        key_valid    = 1'b0;
        key_code     = 3'd0;
        quiet("over_ignores", 10);
        check("over_held", 32'(game_over), 32'd1);
        check("dropped_sticky", 32'(key_dropped), 32'd1);
        press(3'd1);
        check("esc_clears_over", 32'(game_over), 32'd0);
        check("esc_clears_dropped", 32'(key_dropped), 32'd0);
        wait_cmd("esc_clear", 4'd9, 4, gap);
        wait_cmd("esc_spawn", 4'd1, 8, gap);
        repeat (3) tick();
        check("esc_play", 32'(busy), 32'd0);
        quiet("esc_nothing_pending", 10);

        // Reset in the middle of a drop
        down_ok = 1'b1;
        press(3'd2);
        wait_cmd("pre_rst_drop", 4'd6, 8, gap);
        rst = 1'b1;
        tick();
        check("rst_mid_drop_cmd", 32'(cmd), 32'd0);
        tick();
        check("rst_mid_drop_busy", 32'(busy), 32'd1);
        check("rst_mid_drop_cmd2", 32'(cmd), 32'd0);
        rst = 1'b0;
        wait_cmd("post_rst_first", 4'd9, 6, gap);
        check("post_rst_lat", 32'(gap), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
